// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the arbiter and its CPU, DMA and memory neighbours.
// The arbiter takes the slave view; the surrounding system/bench takes the master view.
interface mem_bus_arbiter_if;
  // CPU side
  logic [11:0] iCPU_ADDR;
  logic [11:0] iCPU_DATA;
  logic        iCPU_CSELn;
  logic        iCPU_WR_ENn;
  logic [11:0] oCPU_DATA;
  // DMA side
  logic        iDMA_REQ;
  logic        iDMA_WR;
  logic [11:0] iDMA_ADDR;
  logic [11:0] iDMA_WDATA;
  logic [11:0] oDMA_RDATA;
  logic        oDMA_ACK;
  logic        oDMA_ERR;
  logic        oDMA_BUSY;
  // Memory side
  logic [11:0] iMEM_DATA;
  logic [11:0] oMEM_ADDR;
  logic [11:0] oMEM_DATA;
  logic        oMEM_CSELn;
  logic        oMEM_WR_ENn;

  modport slave (
    input  iCPU_ADDR, iCPU_DATA, iCPU_CSELn, iCPU_WR_ENn,
    output oCPU_DATA,
    input  iDMA_REQ, iDMA_WR, iDMA_ADDR, iDMA_WDATA,
    output oDMA_RDATA, oDMA_ACK, oDMA_ERR, oDMA_BUSY,
    input  iMEM_DATA,
    output oMEM_ADDR, oMEM_DATA, oMEM_CSELn, oMEM_WR_ENn
  );

  modport master (
    output iCPU_ADDR, iCPU_DATA, iCPU_CSELn, iCPU_WR_ENn,
    input  oCPU_DATA,
    output iDMA_REQ, iDMA_WR, iDMA_ADDR, iDMA_WDATA,
    input  oDMA_RDATA, oDMA_ACK, oDMA_ERR, oDMA_BUSY,
    output iMEM_DATA,
    input  oMEM_ADDR, oMEM_DATA, oMEM_CSELn, oMEM_WR_ENn
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one 12-bit memory bus between the CPU (absolute priority, combinational
// pass-through) and a DMA port whose multi-cycle accesses run in idle gaps, are
// aborted whenever the CPU selects memory, retried, and flagged after too many aborts.
module mem_bus_arbiter #(
  parameter int unsigned P_DMA_CYC   = 2,
  parameter int unsigned P_MAX_RETRY = 4
) (
  input logic               iCLK,
  input logic               iRESETn,
  mem_bus_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = (P_DMA_CYC > 1) ? $clog2(P_DMA_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(P_DMA_CYC - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(P_MAX_RETRY);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DMA  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_ACK  = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [11:0]      addr_q, addr_d;
  logic [11:0]      wdata_q, wdata_d;
  logic             wr_q, wr_d;
  logic [11:0]      rdata_q, rdata_d;

  logic       cpu_sel;
  logic [3:0] retry_inc;

  assign cpu_sel   = ~bus.iCPU_CSELn;
  assign retry_inc = retry_q + 4'd1;

  // Next-state logic for the DMA transaction FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    case (state_q)
      // ACK returns to IDLE but also samples a still-held request like IDLE does, so
      // back-to-back accesses cost P_DMA_CYC+1 clocks each instead of paying an extra idle cycle.
      S_IDLE, S_ACK: begin
        if (state_q == S_ACK) begin
          retry_d = 4'd0;
          state_d = S_IDLE;
        end
        if (bus.iDMA_REQ) begin
          addr_d  = bus.iDMA_ADDR;
          wdata_d = bus.iDMA_WDATA;
          wr_d    = bus.iDMA_WR;
          cnt_d   = '0;
          state_d = cpu_sel ? S_WAIT : S_DMA;
        end
      end
      S_DMA: begin
        if (cpu_sel) begin
          // retry never exceeds RETRY_MAX because reaching it leaves for ERR
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_MAX) ? S_ERR : S_WAIT;
        end else if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          if (!wr_q) rdata_d = bus.iMEM_DATA;
          state_d = S_ACK;
        end
      end
      S_WAIT: begin
        // Full restart: a partially completed write is simply rewritten.
        if (!cpu_sel) begin
          cnt_d   = '0;
          state_d = S_DMA;
        end
      end
      S_ERR: begin
        if (!bus.iDMA_REQ) begin
          retry_d = 4'd0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latch registers; reset abandons any access in flight.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      retry_q <= 4'd0;
      addr_q  <= 12'd0;
      wdata_q <= 12'd0;
      wr_q    <= 1'b0;
      rdata_q <= 12'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus mux: CPU always wins, DMA drives only while in DMA, otherwise the bus is parked.
  always_comb begin
    bus.oMEM_ADDR   = 12'd0;
    bus.oMEM_DATA   = 12'd0;
    bus.oMEM_CSELn  = 1'b1;
    bus.oMEM_WR_ENn = 1'b1;
    if (cpu_sel) begin
      bus.oMEM_ADDR   = bus.iCPU_ADDR;
      bus.oMEM_DATA   = bus.iCPU_DATA;
      bus.oMEM_CSELn  = 1'b0;
      bus.oMEM_WR_ENn = bus.iCPU_WR_ENn;
    end else if (state_q == S_DMA) begin
      bus.oMEM_ADDR   = addr_q;
      bus.oMEM_DATA   = wdata_q;
      bus.oMEM_CSELn  = 1'b0;
      // cycle 0 is address setup; strobe only afterwards
      bus.oMEM_WR_ENn = ~(wr_q && (cnt_q != '0));
    end
  end

  // Status and read-data outputs.
  always_comb begin
    bus.oCPU_DATA  = bus.iMEM_DATA;
    bus.oDMA_RDATA = rdata_q;
    bus.oDMA_ACK   = (state_q == S_ACK);
    bus.oDMA_ERR   = (state_q == S_ERR);
    bus.oDMA_BUSY  = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a small memory model and an ACK/ERR scoreboard.
module tb_mem_bus_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  typedef struct {
    logic        err;
    logic [11:0] rdata;
  } exp_t;

  exp_t exp_q[$];

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(
    .P_DMA_CYC  (2),
    .P_MAX_RETRY(4)
  ) dut (
    .iCLK   (clk),
    .iRESETn(rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: asynchronous read, write on rising edge when selected and strobed.
  logic [11:0] mem [0:4095];
  assign bus.iMEM_DATA = mem[bus.oMEM_ADDR];
  always @(posedge clk) begin
    if (!bus.oMEM_CSELn && !bus.oMEM_WR_ENn) mem[bus.oMEM_ADDR] <= bus.oMEM_DATA;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops an expectation on each ACK pulse and each ERR assertion.
  logic err_prev;
  always @(negedge clk) begin
    if (!rst_n) begin
      err_prev <= 1'b0;
    end else begin
      err_prev <= bus.oDMA_ERR;
      if (bus.oDMA_ACK) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_ack: got ack=1 expected none (t=%0t)", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_ack_kind", 32'(e.err), 32'd0);
          chk("sb_rdata", 32'(bus.oDMA_RDATA), 32'(e.rdata));
        end
      end
      if (bus.oDMA_ERR && !err_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_err: got err=1 expected none (t=%0t)", $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_err_kind", 32'(e.err), 32'd1);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [11:0] a, input logic [11:0] d);
    bus.iCPU_ADDR   = a;
    bus.iCPU_DATA   = d;
    bus.iCPU_CSELn  = 1'b0;
    bus.iCPU_WR_ENn = 1'b0;
    tick(1);
    bus.iCPU_CSELn  = 1'b1;
    bus.iCPU_WR_ENn = 1'b1;
  endtask

  task automatic cpu_read_chk(input string name, input logic [11:0] a, input logic [11:0] d);
    bus.iCPU_ADDR  = a;
    bus.iCPU_CSELn = 1'b0;
    #1;
    chk(name, 32'(bus.oCPU_DATA), 32'(d));
    bus.iCPU_CSELn = 1'b1;
    #1;
  endtask

  task automatic dma_req(input logic wr, input logic [11:0] a, input logic [11:0] d);
    bus.iDMA_WR    = wr;
    bus.iDMA_ADDR  = a;
    bus.iDMA_WDATA = d;
    bus.iDMA_REQ   = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n           = 1'b0;
    bus.iCPU_ADDR   = 12'd0;
    bus.iCPU_DATA   = 12'd0;
    bus.iCPU_CSELn  = 1'b1;
    bus.iCPU_WR_ENn = 1'b1;
    bus.iDMA_REQ    = 1'b0;
    bus.iDMA_WR     = 1'b0;
    bus.iDMA_ADDR   = 12'd0;
    bus.iDMA_WDATA  = 12'd0;

    // Reset state
    #2;
    chk("rst_cseln", 32'(bus.oMEM_CSELn), 32'd1);
    chk("rst_wrenn", 32'(bus.oMEM_WR_ENn), 32'd1);
    chk("rst_addr", 32'(bus.oMEM_ADDR), 32'd0);
    chk("rst_mdata", 32'(bus.oMEM_DATA), 32'd0);
    chk("rst_flags", {29'd0, bus.oDMA_ACK, bus.oDMA_ERR, bus.oDMA_BUSY}, 32'd0);
    chk("rst_rdata", 32'(bus.oDMA_RDATA), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Preload through the CPU pass-through
    bus.iCPU_ADDR   = 12'o0100;
    bus.iCPU_DATA   = 12'o1234;
    bus.iCPU_CSELn  = 1'b0;
    bus.iCPU_WR_ENn = 1'b0;
    #1;
    chk("cpu_pass_addr", 32'(bus.oMEM_ADDR), 32'(12'o0100));
    chk("cpu_pass_wr", {30'd0, bus.oMEM_CSELn, bus.oMEM_WR_ENn}, 32'd0);
    tick(1);
    bus.iCPU_CSELn  = 1'b1;
    bus.iCPU_WR_ENn = 1'b1;
    cpu_write(12'o0300, 12'o0555);
    cpu_write(12'o0001, 12'o0011);
    cpu_write(12'o0002, 12'o0022);
    cpu_read_chk("cpu_read", 12'o0100, 12'o1234);

    // DMA read, CPU idle: ACK after the third edge
    exp_q.push_back('{1'b0, 12'o1234});
    dma_req(1'b0, 12'o0100, 12'o0000);
    tick(2);
    chk("rd_ack_early", 32'(bus.oDMA_ACK), 32'd0);
    chk("rd_busy", 32'(bus.oDMA_BUSY), 32'd1);
    tick(1);
    chk("rd_ack", 32'(bus.oDMA_ACK), 32'd1);
    chk("rd_rdata", 32'(bus.oDMA_RDATA), 32'(12'o1234));
    bus.iDMA_REQ = 1'b0;
    tick(1);
    chk("rd_idle", {30'd0, bus.oDMA_ACK, bus.oDMA_BUSY}, 32'd0);

    // DMA write: strobe only in cycle 1; read data keeps the previous capture
    exp_q.push_back('{1'b0, 12'o1234});
    dma_req(1'b1, 12'o0200, 12'o7070);
    tick(1);
    chk("wr_c0_sel", {30'd0, bus.oMEM_CSELn, bus.oMEM_WR_ENn}, 32'd1);
    chk("wr_c0_addr", 32'(bus.oMEM_ADDR), 32'(12'o0200));
    tick(1);
    chk("wr_c1_sel", {30'd0, bus.oMEM_CSELn, bus.oMEM_WR_ENn}, 32'd0);
    chk("wr_c1_data", 32'(bus.oMEM_DATA), 32'(12'o7070));
    tick(1);
    chk("wr_ack", 32'(bus.oDMA_ACK), 32'd1);
    chk("wr_ack_bus", {30'd0, bus.oMEM_CSELn, bus.oMEM_WR_ENn}, 32'd3);
    bus.iDMA_REQ = 1'b0;
    tick(1);
    cpu_read_chk("wr_mem", 12'o0200, 12'o7070);

    // CPU preempts in DMA cycle 1, then releases: full restart
    exp_q.push_back('{1'b0, 12'o0555});
    dma_req(1'b0, 12'o0300, 12'o0000);
    tick(2);
    bus.iCPU_ADDR  = 12'o0777;
    bus.iCPU_CSELn = 1'b0;
    #1;
    chk("pre_cpu_addr", 32'(bus.oMEM_ADDR), 32'(12'o0777));
    tick(1);
    chk("pre_wait", {30'd0, bus.oDMA_BUSY, bus.oDMA_ACK}, 32'd2);
    bus.iCPU_CSELn = 1'b1;
    #1;
    chk("pre_wait_bus", 32'(bus.oMEM_CSELn), 32'd1);
    tick(2);
    chk("pre_ack_early", 32'(bus.oDMA_ACK), 32'd0);
    tick(1);
    chk("pre_ack", 32'(bus.oDMA_ACK), 32'd1);
    bus.iDMA_REQ = 1'b0;
    tick(1);

    // Retry limit: CPU hits every attempt four times
    exp_q.push_back('{1'b1, 12'o0000});
    dma_req(1'b0, 12'o0100, 12'o0000);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      bus.iCPU_CSELn = 1'b0;
      tick(1);
      bus.iCPU_CSELn = 1'b1;
      if (i < 3) chk("retry_no_err", 32'(bus.oDMA_ERR), 32'd0);
    end
    #1;
    chk("retry_err", 32'(bus.oDMA_ERR), 32'd1);
    chk("retry_err_bus", 32'(bus.oMEM_CSELn), 32'd1);
    tick(2);
    chk("retry_err_held", {30'd0, bus.oDMA_ERR, bus.oDMA_ACK}, 32'd2);
    bus.iDMA_REQ = 1'b0;
    tick(1);
    chk("retry_clear", {30'd0, bus.oDMA_ERR, bus.oDMA_BUSY}, 32'd0);
    exp_q.push_back('{1'b0, 12'o1234});
    dma_req(1'b0, 12'o0100, 12'o0000);
    tick(3);
    chk("retry_next_ack", 32'(bus.oDMA_ACK), 32'd1);
    bus.iDMA_REQ = 1'b0;
    tick(1);

    // Back-to-back: two ACKs three clocks apart; mid-access address change ignored
    exp_q.push_back('{1'b0, 12'o0011});
    exp_q.push_back('{1'b0, 12'o0022});
    dma_req(1'b0, 12'o0001, 12'o0000);
    tick(1);
    bus.iDMA_ADDR = 12'o0002;
    tick(2);
    chk("b2b_ack1", 32'(bus.oDMA_ACK), 32'd1);
    chk("b2b_rdata1", 32'(bus.oDMA_RDATA), 32'(12'o0011));
    tick(2);
    chk("b2b_gap", 32'(bus.oDMA_ACK), 32'd0);
    tick(1);
    chk("b2b_ack2", 32'(bus.oDMA_ACK), 32'd1);
    chk("b2b_rdata2", 32'(bus.oDMA_RDATA), 32'(12'o0022));
    bus.iDMA_REQ = 1'b0;
    tick(1);
    chk("b2b_idle", 32'(bus.oDMA_BUSY), 32'd0);

    // Asynchronous reset mid-DMA: no ACK, bus released at once
    dma_req(1'b0, 12'o0100, 12'o0000);
    tick(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_cseln", 32'(bus.oMEM_CSELn), 32'd1);
    chk("arst_flags", {29'd0, bus.oDMA_ACK, bus.oDMA_ERR, bus.oDMA_BUSY}, 32'd0);
    chk("arst_rdata", 32'(bus.oDMA_RDATA), 32'd0);
    bus.iDMA_REQ = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(3);
    chk("arst_after", {30'd0, bus.oDMA_ACK, bus.oDMA_BUSY}, 32'd0);

    tick(2);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
